cordic_phase_nco: RTL and testbench
===================================

Name: cordic_phase_nco

Overview:
Upstream phase/operand generator for the pipelined sin/cos CORDIC stage. It runs a degree-domain phase accumulator and splits each phase into a quadrant (Phase[9:8]) and an integer residual angle of 0..89 degrees (Phase[7:0]). It drives amplitude X and Y=0, one sample per clock, in bursts or continuously. A Cordic_Valid tag is aligned with the CORDIC's 12-cycle latency so downstream logic knows when Sin/Cos are meaningful.

Parameters:
CORDIC_LAT, 12, cycles from Phase sampled by CORDIC to its Sin/Cos register update
DEG360, 92160, 360 degrees in Q9.8 (accumulator modulus)
DEG90, 23040, 90 degrees in Q9.8

Ports:
CLK_50M  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
Start  in  1  pulse; begin a run (accepted only in IDLE)
Stop  in  1  level/pulse; end RUN early
Step  in  16  phase increment, Q8.8 degrees/sample (0..255.996 deg)
Burst_Len  in  16  samples per run; 0 = continuous until Stop
Amp  in  16  signed amplitude, driven on X
X  out  16  CORDIC X operand
Y  out  16  CORDIC Y operand (always 0)
Phase  out  16  {6'b0, quadrant[1:0], degrees[7:0]}
Phase_Valid  out  1  Phase/X/Y carry a new sample this cycle
Cordic_Valid  out  1  Phase_Valid delayed CORDIC_LAT cycles
Busy  out  1  high in RUN or DRAIN
Done  out  1  one-cycle pulse when DRAIN completes

Behaviour:
- Reset (RST=1 at edge): state IDLE; Acc=0, count=0; X=Y=Phase=0; Phase_Valid=Cordic_Valid=Busy=Done=0; valid delay line cleared. Reset mid-run aborts with no Done.
- FSM IDLE/RUN/DRAIN.
  - IDLE: if Start&!Stop: latch Step, Burst_Len, Amp; Acc=0; count=0; go RUN. Stop wins over a simultaneous Start.
  - RUN: each cycle output the current Acc sample, Phase_Valid=1, Acc advances, count+1. Go DRAIN after the Burst_Len-th sample (Burst_Len!=0), or at an edge where Stop=1. Start is ignored.
  - DRAIN: Phase_Valid=0. Wait CORDIC_LAT cycles, then Done=1 for one cycle and go IDLE. Start and Stop are ignored.
- Output timing: the cycle after the Start edge, Phase_Valid=1 with phase 0. Burst_Len=N gives exactly N consecutive valid cycles. A Stop sampled at edge k means no valid cycle after k.
- Accumulator: 17-bit Q9.8, range 0..DEG360-1.
  - Sum = Acc+Step (18 bit); if Sum>=DEG360 subtract DEG360. A single subtract suffices because Step<DEG360.
- Split (combinational from Acc, registered into Phase):
  - q=3 if Acc>=3*DEG90, 2 if >=2*DEG90, 1 if >=DEG90, else 0.
  - r=Acc-q*DEG90 (0..23039).
  - Phase[7:0]=r[15:8] truncated (0..89); Phase[9:8]=q.
- X=latched Amp, Y=0, held for the whole run. Phase/X/Y hold their last value when Phase_Valid=0.
- Cordic_Valid: CORDIC_LAT-deep shift register of Phase_Valid; keeps shifting during DRAIN and IDLE.
- Busy=1 in RUN and DRAIN. Busy falls the same cycle Done=1.
- Step=0 is legal: constant phase.

Optional Feature:
PHASE_ROUND_EN
- Defined: degrees=(r+128)>>8, rounding to nearest. If the result is 90, degrees=0 and quadrant=(q+1) mod 4, which wraps 359.5+ to quadrant 0, 0 deg.
- Undefined: truncation as above. No other behaviour differs.

Test Plan:
1. Hold RST 3 cycles mid-RUN (continuous) -> all outputs 0, IDLE, no Done; Start afterwards restarts at Phase=0x0000.
2. Step=0x5A00 (90 deg), Burst_Len=4, Amp=0x0100, Start -> Phase 0x0000,0x0100,0x0200,0x0300 on 4 valid cycles; X=0x0100, Y=0; Cordic_Valid high for 4 cycles starting 12 cycles after the first Phase_Valid; Done at DRAIN end.
3. Wrap: Step=0xC800 (200 deg), Burst_Len=4 -> Phase 0x0000,0x0214,0x0028,0x023C.
4. Fraction: Step=0x0180 (1.5 deg), Burst_Len=4 -> 0x0000,0x0001,0x0003,0x0004. With PHASE_ROUND_EN -> 0x0000,0x0002,0x0003,0x0005.
5. Round boundary (PHASE_ROUND_EN): Step=0x5980 (89.5 deg), Burst_Len=2 -> 0x0000,0x0100. Without the macro -> 0x0000,0x0059.
6. Burst_Len=0, Step=0x0100; Stop high after 5 valid cycles -> exactly 5 valid samples 0x0000..0x0004. Start during RUN/DRAIN ignored. Simultaneous Start+Stop in IDLE -> stays IDLE.

Source files
------------

// File: rtl/cordic_phase_nco.sv
// Phase/operand generator for the pipelined sin/cos CORDIC: degree-domain NCO with quadrant split.
// Define PHASE_ROUND_EN to round the residual degrees to nearest instead of truncating.
module cordic_phase_nco #(
    parameter int CORDIC_LAT = 12,
    parameter int DEG360     = 92160,
    parameter int DEG90      = 23040
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic        Start,
    input  logic        Stop,
    input  logic [15:0] Step,
    input  logic [15:0] Burst_Len,
    input  logic [15:0] Amp,
    output logic [15:0] X,
    output logic [15:0] Y,
    output logic [15:0] Phase,
    output logic        Phase_Valid,
    output logic        Cordic_Valid,
    output logic        Busy,
    output logic        Done
);

    localparam int DW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
    localparam logic [16:0] D90  = 17'(DEG90);
    localparam logic [16:0] D180 = 17'(2 * DEG90);
    localparam logic [16:0] D270 = 17'(3 * DEG90);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, next_state;

    logic [16:0]           acc, acc_next;
    logic [17:0]           sum;
    logic [15:0]           step_l, len_l, count;
    logic [DW-1:0]         drain_cnt;
    logic [CORDIC_LAT-1:0] valid_sr;
    logic [1:0]            quad, quad_out;
    logic [15:0]           resid;
    logic [7:0]            deg;
    logic [15:0]           split_phase;
`ifdef PHASE_ROUND_EN
    logic [16:0]           resid_rnd;
    logic [7:0]            deg_rnd;
`endif

    // acc always holds the sample currently on Phase; acc_next is the one after it
    always_comb begin
        sum      = {1'b0, acc} + {2'b00, step_l};
        acc_next = (sum >= 18'(DEG360)) ? 17'(sum - 18'(DEG360)) : sum[16:0];
    end

    always_comb begin
        quad = 2'd0;
        resid = 16'(acc_next);
        if (acc_next >= D270) begin
            quad  = 2'd3;
            resid = 16'(acc_next - D270);
        end else if (acc_next >= D180) begin
            quad  = 2'd2;
            resid = 16'(acc_next - D180);
        end else if (acc_next >= D90) begin
            quad  = 2'd1;
            resid = 16'(acc_next - D90);
        end
        quad_out = quad;
`ifdef PHASE_ROUND_EN
        // rounding 89.5+ up to 90 carries into the next quadrant (360 wraps to 0)
        resid_rnd = {1'b0, resid} + 17'd128;
        deg_rnd   = 8'(resid_rnd >> 8);
        if (deg_rnd == 8'd90) begin
            deg      = 8'd0;
            quad_out = quad + 2'd1;
        end else begin
            deg = deg_rnd;
        end
`else
        deg = 8'(resid >> 8);
`endif
        split_phase = {6'b0, quad_out, deg};
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start && !Stop) next_state = RUN;
            RUN:     if (Stop || (len_l != 16'd0 && count == len_l)) next_state = DRAIN;
            DRAIN:   if (drain_cnt == DW'(CORDIC_LAT - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign Busy         = (state != IDLE);
    assign Cordic_Valid = valid_sr[CORDIC_LAT-1];

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            acc         <= '0;
            count       <= '0;
            step_l      <= '0;
            len_l       <= '0;
            drain_cnt   <= '0;
            valid_sr    <= '0;
            X           <= '0;
            Y           <= '0;
            Phase       <= '0;
            Phase_Valid <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done        <= 1'b0;
            Phase_Valid <= 1'b0;
            valid_sr    <= {valid_sr[CORDIC_LAT-2:0], Phase_Valid};
            case (state)
                IDLE: if (next_state == RUN) begin
                    step_l      <= Step;
                    len_l       <= Burst_Len;
                    X           <= Amp;
                    Y           <= '0;
                    acc         <= '0;
                    Phase       <= '0;
                    count       <= 16'd1;
                    Phase_Valid <= 1'b1;
                end
                RUN: if (next_state == RUN) begin
                    acc         <= acc_next;
                    Phase       <= split_phase;
                    count       <= count + 16'd1;
                    Phase_Valid <= 1'b1;
                end else begin
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (next_state == IDLE) Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_phase_nco.sv
// Scoreboard bench for cordic_phase_nco: directed bursts, reset abort, Stop/Start corner cases.
module tb_cordic_phase_nco;

    logic        CLK_50M = 1'b0;
    logic        RST, Start, Stop;
    logic [15:0] Step, Burst_Len, Amp;
    logic [15:0] X, Y, Phase;
    logic        Phase_Valid, Cordic_Valid, Busy, Done;

    typedef struct {
        logic [15:0] phase;
        logic [15:0] x;
    } exp_t;

    exp_t exp_q[$];
    int   pv_cycle_q[$];
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   done_seen = 0;
    int   done_expected = 0;

    cordic_phase_nco dut (
        .CLK_50M(CLK_50M), .RST(RST), .Start(Start), .Stop(Stop),
        .Step(Step), .Burst_Len(Burst_Len), .Amp(Amp),
        .X(X), .Y(Y), .Phase(Phase),
        .Phase_Valid(Phase_Valid), .Cordic_Valid(Cordic_Valid),
        .Busy(Busy), .Done(Done)
    );

    always #10 CLK_50M = ~CLK_50M;
    always @(posedge CLK_50M) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_50M);
        #2;
    endtask

    // Scoreboard monitor: pops an expectation for every valid sample, checks CORDIC tag latency
    always @(negedge CLK_50M) begin
        exp_t e;
        if (Phase_Valid) begin
            pv_cycle_q.push_back(cycle);
            if (exp_q.size() == 0) begin
                checkOutput("extra_sample", 32'(Phase_Valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("phase", 32'(Phase), 32'(e.phase));
                checkOutput("x", 32'(X), 32'(e.x));
                checkOutput("y", 32'(Y), 32'd0);
            end
        end
        if (Cordic_Valid) begin
            if (pv_cycle_q.size() == 0) checkOutput("extra_cordic_valid", 32'(Cordic_Valid), 32'd0);
            else checkOutput("cordic_latency", 32'(cycle - pv_cycle_q.pop_front()), 32'd12);
        end
        if (Done) begin
            done_seen++;
            checkOutput("busy_at_done", 32'(Busy), 32'd0);
        end
        if (RST) pv_cycle_q.delete();
    end

    task automatic applyStimulus(input logic [15:0] step, input logic [15:0] len, input logic [15:0] amp,
                                 input logic [15:0] ph [8], input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.phase = ph[i];
            e.x     = amp;
            exp_q.push_back(e);
        end
        Step      = step;
        Burst_Len = len;
        Amp       = amp;
        Start     = 1'b1;
        tick(1);
        Start     = 1'b0;
        Step      = 16'h1234;
        Burst_Len = 16'h0007;
        Amp       = 16'hDEAD;
    endtask

    task automatic waitDone(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_50M);
            if (Done) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(got), 32'd1);
        done_expected++;
        tick(1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1'b1; Start = 1'b0; Stop = 1'b0;
        Step = '0; Burst_Len = '0; Amp = '0;
        tick(3);
        checkOutput("reset_x", 32'(X), 32'd0);
        checkOutput("reset_phase", 32'({Y, Phase}), 32'd0);
        checkOutput("reset_flags", 32'({Phase_Valid, Cordic_Valid, Busy, Done}), 32'd0);
        RST = 1'b0;
        tick(2);

        // Continuous run aborted by a 3-cycle reset after three samples
        applyStimulus(16'h0100, 16'd0, 16'h0100, '{16'h0000, 16'h0001, 16'h0002, 0, 0, 0, 0, 0}, 3);
        tick(2);
        RST = 1'b1;
        tick(3);
        checkOutput("midrun_reset_phase", 32'({X, Phase}), 32'd0);
        checkOutput("midrun_reset_flags", 32'({Y, Phase_Valid, Cordic_Valid, Busy, Done}), 32'd0);
        RST = 1'b0;
        tick(2);
        checkOutput("idle_after_reset", 32'(Busy), 32'd0);
        applyStimulus(16'h0100, 16'd2, 16'h0100, '{16'h0000, 16'h0001, 0, 0, 0, 0, 0, 0}, 2);
        waitDone("done_restart");

        // 90-degree steps, Start pulses ignored in RUN and in DRAIN
        applyStimulus(16'h5A00, 16'd4, 16'h0100, '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 0}, 4);
        tick(1);
        checkOutput("busy_run", 32'(Busy), 32'd1);
        Start = 1'b1; tick(1); Start = 1'b0;
        tick(4);
        Start = 1'b1; tick(1); Start = 1'b0;
        waitDone("done_90deg");

        applyStimulus(16'hC800, 16'd4, 16'h0100, '{16'h0000, 16'h0214, 16'h0028, 16'h023C, 0, 0, 0, 0}, 4);
        waitDone("done_wrap");

`ifdef PHASE_ROUND_EN
        applyStimulus(16'h0180, 16'd4, 16'h0200, '{16'h0000, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0}, 4);
        waitDone("done_fraction");
        applyStimulus(16'h5980, 16'd2, 16'h0200, '{16'h0000, 16'h0100, 0, 0, 0, 0, 0, 0}, 2);
        waitDone("done_round_boundary");
`else
        applyStimulus(16'h0180, 16'd4, 16'h0200, '{16'h0000, 16'h0001, 16'h0003, 16'h0004, 0, 0, 0, 0}, 4);
        waitDone("done_fraction");
        applyStimulus(16'h5980, 16'd2, 16'h0200, '{16'h0000, 16'h0059, 0, 0, 0, 0, 0, 0}, 2);
        waitDone("done_round_boundary");
`endif

        // Continuous run ended by Stop after five samples
        applyStimulus(16'h0100, 16'd0, 16'h7FFF,
                      '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0, 0}, 5);
        tick(4);
        Stop = 1'b1; tick(1); Stop = 1'b0;
        waitDone("done_stop");

        Start = 1'b1; Stop = 1'b1;
        tick(1);
        Start = 1'b0; Stop = 1'b0;
        tick(3);
        checkOutput("start_stop_idle", 32'(Busy), 32'd0);

        applyStimulus(16'h5A00, 16'd1, 16'h1111, '{16'h0000, 0, 0, 0, 0, 0, 0, 0}, 1);
        waitDone("done_len1");

        applyStimulus(16'h0000, 16'd3, 16'h8001, '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0}, 3);
        waitDone("done_step0");

        tick(20);
        checkOutput("samples_outstanding", 32'(exp_q.size()), 32'd0);
        checkOutput("cordic_tags_outstanding", 32'(pv_cycle_q.size()), 32'd0);
        checkOutput("done_count", 32'(done_seen), 32'(done_expected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
